ex_muldiv_hilo: RTL

//   EX-stage multiply/divide unit with architectural HI/LO registers. Consumes the

---
 rtl/mips_ex_pkg.sv | 15 +
 rtl/ex_div_iter.sv | 39 +++
 rtl/ex_muldiv_hilo.sv | 132 +++++++++++++
 3 files changed

// File: rtl/mips_ex_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit.
// The FSM encoding is a plain logic vector so that legacy code can compare against raw values.
package mips_ex_pkg;

    typedef logic [1:0] md_state_t;

    localparam md_state_t IDLE = 2'd0;
    localparam md_state_t MUL  = 2'd1;
    localparam md_state_t DIV  = 2'd2;
    localparam md_state_t FIX  = 2'd3;

    localparam int MUL_LAT_DEFAULT = 3;
    localparam int DIV_ITER        = 32;

endpackage

// File: rtl/ex_div_iter.sv
// Radix-2 restoring divider on unsigned magnitudes, producing one quotient bit per step.
// A zero divisor still runs to completion; the remainder then ends up equal to the dividend.
module ex_div_iter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] divReg;
    logic [32:0] shifted;
    logic [32:0] diff;

    always_comb begin
        shifted = {remainder, quotient[31]};
        diff    = shifted - {1'b0, divReg};
    end

    // The quotient register doubles as the dividend shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            quotient  <= '0;
            remainder <= '0;
            divReg    <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            divReg    <= divisor;
        end else if (step) begin
            remainder <= diff[32] ? shifted[31:0] : diff[31:0];
            quotient  <= {quotient[30:0], ~diff[32]};
        end
    end

endmodule

// File: rtl/ex_muldiv_hilo.sv
// EX-stage multiply/divide unit with the architectural HI/LO registers, running MULT/DIV in
// the background and stalling any HI/LO-touching instruction until the unit is idle.
module ex_muldiv_hilo
    import mips_ex_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEFAULT,
    parameter int XLEN    = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] AE,
    input  logic [XLEN-1:0] BE,
    input  logic            signE,
    input  logic            mulE,
    input  logic            divE,
    input  logic            mthiE,
    input  logic            mtloE,
    input  logic            mfhiE,
    input  logic            mfloE,
    input  logic            flushE,
    input  logic            holdE,
    output logic [XLEN-1:0] hi_loE,
    output logic            md_stallE,
    output logic            md_busy
);

    md_state_t         state;
    logic [XLEN-1:0]   hi;
    logic [XLEN-1:0]   lo;
    logic              launched;
    logic [4:0]        cnt;
    logic [2*XLEN-1:0] product;
    logic [2*XLEN-1:0] mulResult;
    logic              remNeg;
    logic              quoNeg;
    logic              divZero;
    logic [XLEN-1:0]   magA;
    logic [XLEN-1:0]   magB;
    logic [XLEN-1:0]   quotient;
    logic [XLEN-1:0]   remainder;
    logic              hiloOp;
    logic              start;
    logic              divStart;
    logic              mulStart;
    logic              moveWrite;

    always_comb begin
        md_busy   = (state != IDLE);
        hiloOp    = mulE | divE | mthiE | mtloE | mfhiE | mfloE;
        md_stallE = md_busy & hiloOp & ~flushE;
        start     = (mulE | divE) & ~md_busy & ~launched & ~flushE;
        divStart  = start & divE;
        mulStart  = start & ~divE;
        moveWrite = ~md_busy & ~flushE & (mthiE | mtloE) & ~(mulE | divE);
        hi_loE    = mfhiE ? hi : (mfloE ? lo : '0);
        magA      = (signE & AE[XLEN-1]) ? -AE : AE;
        magB      = (signE & BE[XLEN-1]) ? -BE : BE;
        mulResult = signE ? $signed({{XLEN{AE[XLEN-1]}}, AE}) * $signed({{XLEN{BE[XLEN-1]}}, BE})
                          : {{XLEN{1'b0}}, AE} * {{XLEN{1'b0}}, BE};
    end

    ex_div_iter divIter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (divStart),
        .step     (state == DIV),
        .dividend (magA),
        .divisor  (magB),
        .quotient (quotient),
        .remainder(remainder)
    );

    // Clearing 'launched' wins over setting it: if E advances on the start edge, the next
    // instruction in E is a different one and must be free to launch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            launched <= 1'b0;
            cnt      <= '0;
            product  <= '0;
            remNeg   <= 1'b0;
            quoNeg   <= 1'b0;
            divZero  <= 1'b0;
        end else begin
            if (!holdE && !md_stallE) begin
                launched <= 1'b0;
            end else if (start) begin
                launched <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (divStart) begin
                        remNeg  <= signE & AE[XLEN-1];
                        quoNeg  <= signE & (AE[XLEN-1] ^ BE[XLEN-1]);
                        divZero <= (BE == '0);
                        cnt     <= '0;
                        state   <= DIV;
                    end else if (mulStart) begin
                        product <= mulResult;
                        cnt     <= 5'(MUL_LAT - 1);
                        state   <= MUL;
                    end else if (moveWrite) begin
                        if (mthiE) hi <= AE;
                        if (mtloE) lo <= AE;
                    end
                end
                MUL: begin
                    if (cnt == '0) begin
                        {hi, lo} <= product;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                DIV: begin
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(DIV_ITER - 1)) state <= FIX;
                end
                FIX: begin
                    lo    <= divZero ? '1 : (quoNeg ? -quotient : quotient);
                    hi    <= remNeg ? -remainder : remainder;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
